baud_tick_generator: RTL and testbench
======================================

// Module: baud_tick_generator
// PURPOSE
//   Parametrised successor to the fixed-divider UART baud generator. A phase accumulator
//   (fractional-N) produces single-cycle clock-enable pulses instead of derived clocks:
//   an oversample tick, a TX bit tick and a mid-bit RX sample tick. The RX tick re-phases
//   on start-bit detection. The baud rate can be reprogrammed at runtime. It sits between
//   the board clock and the UART TX/RX state machines, which stay on clk.
// PARAMETERS
//   CLOCK_RATE  50000000  board clock frequency, Hz
//   BAUD_RATE   115200    baud rate loaded by reset
//   OVERSAMPLE  16        os_tick per bit; even, >= 4
//   ACC_WIDTH   24        phase accumulator fraction width, 8..32
//   DEF_INC     localparam = (BAUD_RATE*OVERSAMPLE*2**ACC_WIDTH + CLOCK_RATE/2) / CLOCK_RATE,
//                          computed in 64-bit (618475 for the defaults)
// PORTS
//   clk        in   1          board clock, single clock domain
//   rst        in   1          synchronous, active-high reset
//   en         in   1          1 = run; 0 = freeze accumulator and counters
//   cfg_load   in   1          1-cycle strobe: load cfg_inc and restart phase
//   cfg_inc    in   ACC_WIDTH  new increment; os rate = clk * inc / 2**ACC_WIDTH
//   rx_sync    in   1          1-cycle strobe from RX on start-bit falling edge
//   os_tick    out  1          oversample enable pulse
//   tx_tick    out  1          bit-period enable pulse for TX
//   rx_sample  out  1          mid-bit sample enable pulse for RX
//   inc_q      out  ACC_WIDTH  increment currently in use
// BEHAVIOUR
//   - All outputs are registered. Reset (synchronous, checked at the clk edge): acc=0,
//     tx_cnt=0, rx_cnt=0, os_tick=tx_tick=rx_sample=0, inc_q=DEF_INC.
//   - Priority order, highest first: rst, cfg_load, rx_sync, normal operation.
//   - Normal operation (en=1): {carry,acc} <= acc + inc_q, using ACC_WIDTH+1 bits.
//     os_tick <= carry, so a pulse appears one cycle after the overflowing add.
//     Consecutive os_tick pulses are legal when inc_q >= 2**(ACC_WIDTH-1).
//   - tx_cnt counts 0..OVERSAMPLE-1 on each carry and wraps to 0.
//     tx_tick <= carry & (tx_cnt==OVERSAMPLE-1), so it coincides with that os_tick.
//   - rx_cnt also counts 0..OVERSAMPLE-1 on each carry and wraps.
//     rx_sample <= carry & (rx_cnt==OVERSAMPLE-1).
//   - rx_sync: rx_cnt <= OVERSAMPLE/2; acc and tx_cnt are untouched.
//     The first rx_sample coincides with the OVERSAMPLE/2-th os_tick after the strobe,
//     then one every OVERSAMPLE os_ticks. A carry in the same cycle as rx_sync is counted
//     for tx and os_tick, but rx_cnt takes the sync value and rx_sample stays 0.
//   - cfg_load: inc_q <= cfg_inc; acc, tx_cnt and rx_cnt <= 0; all ticks <= 0 next cycle.
//     The new rate takes effect from the following cycle. cfg_load overrides rx_sync.
//   - en=0: acc, tx_cnt and rx_cnt hold; all ticks <= 0. cfg_load and rx_sync are still
//     honoured.
//   - inc_q = 0: no ticks ever (legal idle state).
//   - Long-run accuracy: over 2**ACC_WIDTH enabled cycles, exactly inc_q os_ticks.
//   - rst mid-frame aborts immediately. The next cycle shows all ticks 0 and inc_q=DEF_INC.
// TESTING
//   1 Reset: hold rst 3 cycles mid-run -> all ticks 0, inc_q=618475 on the cycle after
//     release, with default parameters.
//   2 Integer rate (ACC_WIDTH=8, OVERSAMPLE=16): cfg_inc=64 -> os_tick every 4 cycles
//     exactly, tx_tick every 64 cycles, first os_tick 4 cycles after load + 1.
//   3 Fractional rate (ACC_WIDTH=8): cfg_inc=96 -> gaps of 2 or 3 cycles, exactly 96
//     os_ticks and 6 tx_ticks in 256 cycles.
//   4 RX re-phase (inc=64): rx_sync pulse -> rx_sample on the 8th following os_tick, then
//     every 64 cycles; tx_tick phase unchanged. Also rx_sync coincident with an os_tick
//     -> that tick is not counted for RX.
//   5 en low for 10 cycles mid-bit -> no ticks; the counters resume with the same phase
//     offset. Also cfg_load with rx_sync in the same cycle -> counters 0, no rx_sample for
//     16 os_ticks.
//   6 Defaults (50 MHz, 115200): measure 1e6 cycles -> tx_tick count 2304 +/- 1,
//     error < 0.01 %.

Source files
------------

// File: rtl/baud_tick_generator.sv
// baud_tick_generator
//   Fractional-N phase accumulator that produces single-cycle clock enables
//   for a UART: an oversample tick, a TX bit tick and a mid-bit RX sample
//   tick. Everything stays on clk. The RX tick can be re-phased from the
//   receiver's start-bit detector, and the rate can be reprogrammed at runtime.
//
// Ports
//   clk        board clock
//   rst        synchronous active-high reset
//   en         1 = run, 0 = freeze accumulator and counters (ticks forced low)
//   cfg_load   strobe: take cfg_inc as the new increment and restart the phase
//   cfg_inc    new increment; os rate = clk * inc / 2**ACC_WIDTH
//   rx_sync    strobe on RX start-bit falling edge; re-phases rx_sample
//   os_tick    oversample enable pulse
//   tx_tick    bit-period enable pulse (coincides with every OVERSAMPLE-th os_tick)
//   rx_sample  mid-bit sample enable pulse
//   inc_q      increment currently in use
module baud_tick_generator #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic                 rx_sync,
    output logic                 os_tick,
    output logic                 tx_tick,
    output logic                 rx_sample,
    output logic [ACC_WIDTH-1:0] inc_q
);

    // Rounded increment for the reset baud rate, evaluated in 64 bits.
    localparam logic [ACC_WIDTH-1:0] DEF_INC = ACC_WIDTH'(
        (64'(BAUD_RATE) * 64'(OVERSAMPLE) * (64'd1 << ACC_WIDTH) + 64'(CLOCK_RATE) / 64'd2)
        / 64'(CLOCK_RATE));

    localparam int             CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2);

    logic [ACC_WIDTH-1:0] acc;
    logic                 carry;   // registered overflow of the last add
    logic [CNT_W-1:0]     tx_cnt;
    logic [CNT_W-1:0]     rx_cnt;
    logic [ACC_WIDTH:0]   sum;
    logic [CNT_W-1:0]     tx_nxt;
    logic [CNT_W-1:0]     rx_nxt;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, inc_q};
        tx_nxt = (tx_cnt == LAST) ? '0 : tx_cnt + CNT_W'(1);
        rx_nxt = (rx_cnt == LAST) ? '0 : rx_cnt + CNT_W'(1);
    end

    // The carry is registered first and the ticks are registered from it,
    // so all three ticks of one overflow appear together a cycle after the add.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            carry     <= 1'b0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            os_tick   <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            inc_q     <= DEF_INC;
        end else if (cfg_load) begin
            inc_q     <= cfg_inc;
            acc       <= '0;
            carry     <= 1'b0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            os_tick   <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
        end else if (!en) begin
            // Pending carry is held with the rest of the phase so that the
            // tick pattern resumes exactly where it stopped.
            os_tick   <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            if (rx_sync)
                rx_cnt <= HALF;
        end else begin
            {carry, acc} <= sum;
            os_tick      <= carry;
            tx_tick      <= carry && (tx_cnt == LAST);
            // A carry coinciding with rx_sync belongs to the old RX phase.
            rx_sample    <= carry && (rx_cnt == LAST) && !rx_sync;
            if (carry)
                tx_cnt <= tx_nxt;
            if (rx_sync)
                rx_cnt <= HALF;
            else if (carry)
                rx_cnt <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_baud_tick_generator.sv
module tb_baud_tick_generator;

    logic        clk = 1'b0;
    logic        rst, en, cfg_load, rx_sync;
    logic [7:0]  cfg_inc_s;
    logic [23:0] cfg_inc_b;
    logic        os_s, tx_s, rx_s, os_b, tx_b, rx_b;
    logic [7:0]  inc_s;
    logic [23:0] inc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Small instance: 8-bit accumulator, reset increment (4*16*256+128)/256 = 64.
    baud_tick_generator #(.CLOCK_RATE(256), .BAUD_RATE(4), .OVERSAMPLE(16), .ACC_WIDTH(8)) dut_s (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_inc(cfg_inc_s),
        .rx_sync(rx_sync), .os_tick(os_s), .tx_tick(tx_s), .rx_sample(rx_s), .inc_q(inc_s));

    // Default instance: 50 MHz / 115200 / 16 / 24 bits.
    baud_tick_generator dut_b (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_inc(cfg_inc_b),
        .rx_sync(rx_sync), .os_tick(os_b), .tx_tick(tx_b), .rx_sample(rx_b), .inc_q(inc_b));

    // ---------------- scoreboard for the small instance ----------------
    typedef struct {
        logic       os;
        logic       tx;
        logic       rx;
        logic [7:0] inc;
    } exp_t;
    exp_t sbq[$];

    int   m_acc, m_tx, m_rx, m_inc;
    logic m_carry;

    // Reference behaviour of the 8-bit/16x instance, one clock edge per call.
    task automatic model(input logic r, input logic e, input logic l,
                         input logic [7:0] ci, input logic s);
        exp_t x;
        x.os = 1'b0; x.tx = 1'b0; x.rx = 1'b0;
        if (r) begin
            m_acc = 0; m_carry = 1'b0; m_tx = 0; m_rx = 0; m_inc = 64;
        end else if (l) begin
            m_inc = int'(ci); m_acc = 0; m_carry = 1'b0; m_tx = 0; m_rx = 0;
        end else if (!e) begin
            if (s) m_rx = 8;
        end else begin
            x.os = m_carry;
            x.tx = m_carry && (m_tx == 15);
            x.rx = m_carry && (m_rx == 15) && !s;
            if (m_carry) m_tx = (m_tx + 1) % 16;
            if (s) m_rx = 8;
            else if (m_carry) m_rx = (m_rx + 1) % 16;
            m_carry = (m_acc + m_inc) >= 256;
            m_acc   = (m_acc + m_inc) % 256;
        end
        x.inc = m_inc[7:0];
        sbq.push_back(x);
    endtask

    // Drive one cycle, predict, then compare at the falling edge.
    task automatic cyc(input logic r, input logic e, input logic l,
                       input logic [7:0] ci, input logic s);
        exp_t x;
        rst = r; en = e; cfg_load = l; cfg_inc_s = ci; rx_sync = s;
        model(r, e, l, ci, s);
        @(posedge clk);
        @(negedge clk);
        x = sbq.pop_front();
        checks++;
        if (os_s !== x.os || tx_s !== x.tx || rx_s !== x.rx || inc_s !== x.inc) begin
            errors++;
            $display("FAIL sb_small t=%0t: got os=%b tx=%b rx=%b inc=%0d, want os=%b tx=%b rx=%b inc=%0d",
                     $time, os_s, tx_s, rx_s, inc_s, x.os, x.tx, x.rx, x.inc);
        end
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Load inc (optionally with rx_sync), then run n edges with an optional
    // rx_sync at edge sync_at and en low for edges [off_from, off_from+off_len).
    task automatic seq(input logic [7:0] inc, input logic sync_on_load, input int sync_at,
                       input int off_from, input int off_len, input int n,
                       output int rx1, output int rx2, output int tx1, output int tx2,
                       output int os_to_rx1, output int off_ticks);
        logic e;
        rx1 = 0; rx2 = 0; tx1 = 0; tx2 = 0; os_to_rx1 = 0; off_ticks = 0;
        cyc(1'b0, 1'b1, 1'b1, inc, sync_on_load);
        for (int k = 1; k <= n; k++) begin
            e = !(k >= off_from && k < off_from + off_len);
            cyc(1'b0, e, 1'b0, inc, k == sync_at);
            if (!e && (os_s || tx_s || rx_s)) off_ticks++;
            if (os_s && k > sync_at && rx1 == 0) os_to_rx1++;
            if (rx_s) begin if (rx1 == 0) rx1 = k; else if (rx2 == 0) rx2 = k; end
            if (tx_s) begin if (tx1 == 0) tx1 = k; else if (tx2 == 0) tx2 = k; end
        end
    endtask

    // ---------------- rate table ----------------
    typedef struct {
        logic [7:0] inc;
        int n_os;      // os_ticks over edges 1..257 after load
        int n_tx;
        int first_os;  // edge of first os_tick, 0 = none
        int min_gap;
        int max_gap;
    } rate_vec_t;

    initial begin
        rate_vec_t tbl[5];
        int cnt_os, cnt_tx, first, last, gmin, gmax;
        int rx1, rx2, tx1, tx2, osr, offt;
        longint exp_os;
        int n6;

        tbl[0] = '{inc: 8'd64,  n_os: 64,  n_tx: 4,  first_os: 5, min_gap: 4, max_gap: 4};
        tbl[1] = '{inc: 8'd96,  n_os: 96,  n_tx: 6,  first_os: 4, min_gap: 2, max_gap: 3};
        tbl[2] = '{inc: 8'd128, n_os: 128, n_tx: 8,  first_os: 3, min_gap: 2, max_gap: 2};
        tbl[3] = '{inc: 8'd200, n_os: 200, n_tx: 12, first_os: 3, min_gap: 1, max_gap: 2};
        tbl[4] = '{inc: 8'd0,   n_os: 0,   n_tx: 0,  first_os: 0, min_gap: 0, max_gap: 0};

        cfg_inc_b = 24'h400000;

        // 1: reset, run at a fast rate, then reset for 3 cycles mid-run
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("rst_inc_b", inc_b, 618475);
        chk("rst_ticks_b", {os_b, tx_b, rx_b}, 0);
        cyc(1'b0, 1'b1, 1'b1, 8'd128, 1'b0);
        cnt_os = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd128, 1'b0);
            if (os_b) cnt_os++;
        end
        chk("run_inc_b", inc_b, 24'h400000);
        chk("run_os_b", cnt_os, 7);  // 0x400000: carries at edges 4,8,..,28 -> os at 5..29
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'd128, 1'b0);
            chk("in_rst_ticks_b", {os_b, tx_b, rx_b}, 0);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'd128, 1'b0);
        chk("post_rst_ticks_b", {os_b, tx_b, rx_b}, 0);
        chk("post_rst_inc_b", inc_b, 618475);

        // 2/3: integer, fractional, consecutive and idle rates
        foreach (tbl[i]) begin
            cyc(1'b0, 1'b1, 1'b1, tbl[i].inc, 1'b0);
            cnt_os = 0; cnt_tx = 0; first = 0; last = 0; gmin = 1000; gmax = 0;
            for (int k = 1; k <= 257; k++) begin
                cyc(1'b0, 1'b1, 1'b0, tbl[i].inc, 1'b0);
                if (tx_s) cnt_tx++;
                if (os_s) begin
                    cnt_os++;
                    if (first == 0) first = k;
                    else begin
                        if (k - last < gmin) gmin = k - last;
                        if (k - last > gmax) gmax = k - last;
                    end
                    last = k;
                end
            end
            chk($sformatf("n_os[%0d]", tbl[i].inc), cnt_os, tbl[i].n_os);
            chk($sformatf("n_tx[%0d]", tbl[i].inc), cnt_tx, tbl[i].n_tx);
            chk($sformatf("first_os[%0d]", tbl[i].inc), first, tbl[i].first_os);
            if (tbl[i].n_os >= 2) begin
                chk($sformatf("min_gap[%0d]", tbl[i].inc), gmin, tbl[i].min_gap);
                chk($sformatf("max_gap[%0d]", tbl[i].inc), gmax, tbl[i].max_gap);
            end
        end

        // 4a: rx_sync between os_ticks (os at edges 5,9,..)
        seq(8'd64, 1'b0, 23, 0, 0, 150, rx1, rx2, tx1, tx2, osr, offt);
        chk("resync_os_count", osr, 8);
        chk("resync_rx1", rx1, 53);
        chk("resync_rx2", rx2, 117);
        chk("resync_tx1", tx1, 65);
        chk("resync_tx2", tx2, 129);
        // 4b: rx_sync in the cycle of an os_tick -> that tick not counted
        seq(8'd64, 1'b0, 25, 0, 0, 150, rx1, rx2, tx1, tx2, osr, offt);
        chk("coinc_rx1", rx1, 57);
        chk("coinc_tx1", tx1, 65);

        // 5a: en low for 10 cycles mid-bit shifts every tick by 10
        seq(8'd64, 1'b0, -1, 30, 10, 150, rx1, rx2, tx1, tx2, osr, offt);
        chk("en_off_ticks", offt, 0);
        chk("en_tx1", tx1, 75);
        chk("en_tx2", tx2, 139);
        chk("en_rx1", rx1, 75);
        // 5b: cfg_load together with rx_sync: rx counts from 0
        seq(8'd64, 1'b1, -1, 0, 0, 100, rx1, rx2, tx1, tx2, osr, offt);
        chk("load_sync_rx1", rx1, 65);
        chk("load_sync_tx1", tx1, 65);

        // 6: long-run accuracy of the default instance
        n6 = 40000;
        cyc(1'b1, 1'b0, 1'b0, 8'd64, 1'b0);
        cnt_os = 0; cnt_tx = 0;
        for (int k = 1; k <= n6; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd64, 1'b0);
            if (os_b) cnt_os++;
            if (tx_b) cnt_tx++;
        end
        exp_os = (longint'(n6 - 1) * 64'd618475) >> 24;
        chk("acc_os_b", cnt_os, exp_os);
        chk("acc_tx_b", cnt_tx, exp_os / 16);
        // nominal n6 * 115200 / 50e6 = 92.16 bit periods
        checks++;
        if (cnt_tx < 91 || cnt_tx > 93) begin
            errors++;
            $display("FAIL acc_tx_range: got %0d, want 92 +/- 1", cnt_tx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
